// File: rtl/fpu_cpx_pkg.sv
// Shared definitions for the FPU-to-CPX return-packet receiver.
//   - Bit positions of the 145-bit CPX return packet
//   - RTNTYPE_FPU return-type code and reserved-bit mask
//   - cpx_entry_t: record stored per result FIFO entry
//   - pkt_malformed(): well-formedness check of a valid packet
package fpu_cpx_pkg;

  localparam int unsigned PKT_W       = 145;
  localparam int unsigned PKT_VLD_BIT = 144;
  localparam int unsigned RTN_HI      = 143;
  localparam int unsigned RTN_LO      = 140;
  localparam int unsigned THR_HI      = 134;
  localparam int unsigned THR_LO      = 133;
  localparam int unsigned EXC_HI      = 76;
  localparam int unsigned EXC_LO      = 72;
  localparam int unsigned FCMPOP_BIT  = 69;
  localparam int unsigned CC_HI       = 68;
  localparam int unsigned CC_LO       = 67;
  localparam int unsigned FCC_HI      = 66;
  localparam int unsigned FCC_LO      = 65;
  localparam int unsigned DATA_HI     = 63;
  localparam int unsigned DATA_LO     = 0;

  localparam logic [3:0] RTNTYPE_FPU = 4'b1000;

  // Ones at every reserved position: [139:135], [132:77], [71:70], [64]
  localparam logic [PKT_W-1:0] RSVD_MASK = {
    1'b0, 4'b0, 5'h1F, 2'b0, {56{1'b1}}, 5'b0, 2'b11, 5'b0, 1'b1, 64'b0
  };

  typedef struct packed {
    logic [1:0]  thread;
    logic [4:0]  exc;
    logic        fcmpop;
    logic [1:0]  cc;
    logic [1:0]  fcc;
    logic [63:0] data;
  } cpx_entry_t;

  localparam int unsigned ENTRY_W = $bits(cpx_entry_t);

  function automatic logic pkt_malformed(input logic [PKT_W-1:0] pkt);
    return (pkt[RTN_HI:RTN_LO] != RTNTYPE_FPU) || (|(pkt & RSVD_MASK));
  endfunction

endpackage

// File: rtl/fpu_cpx_rcv_if.sv
// Packet / issue / result handshake bundle of fpu_cpx_rcv.
//   fp_cpx_data_ca : 145-bit FPU return packet (bit 144 = valid)
//   issue_vld/issue_thread : FPU op issue notification
//   res_* : result FIFO head with valid/ready handshake
// Modports: slave = receiver (DUT), master = producer/consumer side.
interface fpu_cpx_rcv_if;
  import fpu_cpx_pkg::*;

  logic [PKT_W-1:0] fp_cpx_data_ca;
  logic             issue_vld;
  logic [1:0]       issue_thread;
  logic             res_vld;
  logic             res_rdy;
  logic [1:0]       res_thread;
  logic [4:0]       res_exc;
  logic             res_fcmpop;
  logic [1:0]       res_cc;
  logic [1:0]       res_fcc;
  logic [63:0]      res_data;

  modport master (
    output fp_cpx_data_ca, issue_vld, issue_thread, res_rdy,
    input  res_vld, res_thread, res_exc, res_fcmpop, res_cc, res_fcc, res_data
  );

  modport slave (
    input  fp_cpx_data_ca, issue_vld, issue_thread, res_rdy,
    output res_vld, res_thread, res_exc, res_fcmpop, res_cc, res_fcc, res_data
  );
endinterface

// File: rtl/fpu_cpx_rcv_fifo.sv
// Synchronous FIFO storing result records for fpu_cpx_rcv.
//   clk, rst      : clock, async active-high reset (clears pointers/count/storage)
//   push, wdata   : write request; honoured when not full, or when full with a same-cycle pop
//   pop, rdata    : read request (ignored while empty); rdata is the current head
//   empty, full   : status
//   count         : occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fpu_cpx_rcv_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fpu_cpx_rcv.sv
// FPU-to-CPX return-packet receiver.
// Decodes FPU return packets, checks them against per-thread pending-op
// counters and queues well-formed, expected results in a FIFO.
//   rclk, rst     : clock, async active-high reset
//   cpx (slave)   : packet in, issue notification, result head handshake
//   fifo_cnt      : FIFO occupancy 0..DEPTH
//   err_fmt       : sticky, malformed valid packet dropped
//   err_ovf       : sticky, expected return dropped because FIFO full
//   err_unexp     : sticky, return with no pending op dropped
//   err_clr       : clears sticky flags (a same-cycle new event wins)
module fpu_cpx_rcv
  import fpu_cpx_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PCNT_W = 3
) (
  input  logic                   rclk,
  input  logic                   rst,
  fpu_cpx_rcv_if.slave           cpx,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   err_fmt,
  output logic                   err_ovf,
  output logic                   err_unexp,
  input  logic                   err_clr
);

  logic [PKT_W-1:0]  pkt;
  logic              pkt_vld;
  logic              fmt_bad;
  logic [1:0]        pkt_thr;
  logic              issue_same;
  logic              expected;
  logic              fmt_ev, unexp_ev, ovf_ev;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [3:0]        inc_vec, dec_vec;
  cpx_entry_t        pkt_entry;
  cpx_entry_t        head_raw;
  cpx_entry_t        head;

  logic [PCNT_W-1:0] pcnt_q [4];
  logic [PCNT_W-1:0] pcnt_d [4];
  logic              err_fmt_q, err_fmt_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unexp_q, err_unexp_d;

  assign pkt = cpx.fp_cpx_data_ca;

  // Packet decode and accept/drop classification
  always_comb begin
    pkt_vld          = pkt[PKT_VLD_BIT];
    fmt_bad          = pkt_malformed(pkt);
    pkt_thr          = pkt[THR_HI:THR_LO];
    pkt_entry.thread = pkt[THR_HI:THR_LO];
    pkt_entry.exc    = pkt[EXC_HI:EXC_LO];
    pkt_entry.fcmpop = pkt[FCMPOP_BIT];
    pkt_entry.cc     = pkt[CC_HI:CC_LO];
    pkt_entry.fcc    = pkt[FCC_HI:FCC_LO];
    pkt_entry.data   = pkt[DATA_HI:DATA_LO];

    pop        = ~fifo_empty & cpx.res_rdy;
    // A same-cycle issue for the returning thread makes the return expected
    // even while that thread's counter is still zero.
    issue_same = cpx.issue_vld & (cpx.issue_thread == pkt_thr);
    expected   = (pcnt_q[pkt_thr] != '0) | issue_same;

    fmt_ev   = pkt_vld & fmt_bad;
    unexp_ev = pkt_vld & ~fmt_bad & ~expected;
    ovf_ev   = pkt_vld & ~fmt_bad & expected & fifo_full & ~pop;
    push     = pkt_vld & ~fmt_bad & expected & (~fifo_full | pop);
  end

  // Pending counters: saturating increment, decrement only on accepted push
  always_comb begin
    inc_vec = {3'b0, cpx.issue_vld} << cpx.issue_thread;
    dec_vec = {3'b0, push} << pkt_thr;
    for (int unsigned t = 0; t < 4; t++) begin
      pcnt_d[t] = pcnt_q[t];
      if (inc_vec[t] && !dec_vec[t]) begin
        if (pcnt_q[t] != '1) pcnt_d[t] = pcnt_q[t] + 1'b1;
      end else if (dec_vec[t] && !inc_vec[t]) begin
        pcnt_d[t] = pcnt_q[t] - 1'b1;
      end
    end
  end

  // Sticky error flags; a new event overrides a same-cycle clear
  always_comb begin
    err_fmt_d   = fmt_ev   | (err_fmt_q   & ~err_clr);
    err_ovf_d   = ovf_ev   | (err_ovf_q   & ~err_clr);
    err_unexp_d = unexp_ev | (err_unexp_q & ~err_clr);
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      pcnt_q      <= '{default: '0};
      err_fmt_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      err_fmt_q   <= err_fmt_d;
      err_ovf_q   <= err_ovf_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  fpu_cpx_rcv_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (rclk),
    .rst   (rst),
    .push  (push),
    .wdata (pkt_entry),
    .pop   (pop),
    .rdata (head_raw),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

  // Head fields are forced to zero whenever nothing is valid
  always_comb begin
    head = fifo_empty ? '0 : head_raw;
  end

  assign cpx.res_vld    = ~fifo_empty;
  assign cpx.res_thread = head.thread;
  assign cpx.res_exc    = head.exc;
  assign cpx.res_fcmpop = head.fcmpop;
  assign cpx.res_cc     = head.cc;
  assign cpx.res_fcc    = head.fcc;
  assign cpx.res_data   = head.data;

  assign err_fmt   = err_fmt_q;
  assign err_ovf   = err_ovf_q;
  assign err_unexp = err_unexp_q;

endmodule

// File: tb/tb_fpu_cpx_rcv.sv
module tb_fpu_cpx_rcv;

  localparam int DEPTH  = 4;
  localparam int PCNT_W = 3;
  localparam int PMAX   = (1 << PCNT_W) - 1;

  logic       rclk = 1'b0;
  logic       rst;
  logic [2:0] fifo_cnt;
  logic       err_fmt, err_ovf, err_unexp, err_clr;

  fpu_cpx_rcv_if bus ();

  fpu_cpx_rcv #(.DEPTH(DEPTH), .PCNT_W(PCNT_W)) dut (
    .rclk      (rclk),
    .rst       (rst),
    .cpx       (bus),
    .fifo_cnt  (fifo_cnt),
    .err_fmt   (err_fmt),
    .err_ovf   (err_ovf),
    .err_unexp (err_unexp),
    .err_clr   (err_clr)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [1:0]  thr;
    logic [4:0]  exc;
    logic        fcmpop;
    logic [1:0]  cc;
    logic [1:0]  fcc;
    logic [63:0] data;
  } ent_t;

  // Reference model state
  ent_t q[$];
  int   pend[4];
  bit   m_fmt, m_ovf, m_unexp;

  // Current stimulus
  logic [144:0] pkt;
  bit           iv;
  int           it;
  bit           rdy;
  bit           clr;

  int passed = 0;
  int total  = 0;

  function automatic logic [144:0] mk(input int thr, input logic [4:0] exc,
                                      input logic fcmpop, input logic [1:0] cc,
                                      input logic [1:0] fcc, input logic [63:0] data,
                                      input logic [3:0] rt);
    logic [144:0] p;
    p = '0;
    p[144]     = 1'b1;
    p[143:140] = rt;
    p[134:133] = thr[1:0];
    p[76:72]   = exc;
    p[69]      = fcmpop;
    p[68:67]   = cc;
    p[66:65]   = fcc;
    p[63:0]    = data;
    return p;
  endfunction

  function automatic logic [144:0] rnd_ret(input int thr);
    return mk(thr, 5'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
              {$urandom, $urandom}, 4'b1000);
  endfunction

  // Random garbage with the valid bit clear: must be ignored entirely
  function automatic logic [144:0] idle_pkt();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    r[144] = 1'b0;
    return r[144:0];
  endfunction

  task automatic apply();
    bus.fp_cpx_data_ca = pkt;
    bus.issue_vld      = iv;
    bus.issue_thread   = it[1:0];
    bus.res_rdy        = rdy;
    err_clr            = clr;
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < 4; k++) pend[k] = 0;
    m_fmt = 0; m_ovf = 0; m_unexp = 0;
  endtask

  // What one clock edge does to the receiver, from the packet rules
  task automatic model_edge();
    bit   pop, acc, ev_fmt, ev_unexp, ev_ovf;
    int   t;
    ent_t e;
    pop = rdy && (q.size() > 0);
    acc = 0; ev_fmt = 0; ev_unexp = 0; ev_ovf = 0;
    t = int'(pkt[134:133]);
    e.thr = pkt[134:133]; e.exc = pkt[76:72]; e.fcmpop = pkt[69];
    e.cc = pkt[68:67]; e.fcc = pkt[66:65]; e.data = pkt[63:0];
    if (pkt[144]) begin
      if (pkt[143:140] != 4'b1000 || pkt[139:135] != '0 || pkt[132:77] != '0 ||
          pkt[71:70] != '0 || pkt[64])
        ev_fmt = 1;
      else if (pend[t] == 0 && !(iv && it == t))
        ev_unexp = 1;
      else if (q.size() == DEPTH && !pop)
        ev_ovf = 1;
      else
        acc = 1;
    end
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      bit up, dn;
      up = iv && (it == k);
      dn = acc && (t == k);
      if (up && !dn && pend[k] < PMAX) pend[k]++;
      else if (dn && !up) pend[k]--;
    end
    m_fmt   = ev_fmt   || (m_fmt   && !clr);
    m_ovf   = ev_ovf   || (m_ovf   && !clr);
    m_unexp = ev_unexp || (m_unexp && !clr);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string where);
    bit v;
    v = (q.size() > 0);
    chk({where, "/res_vld"},    64'(bus.res_vld), 64'(v));
    chk({where, "/fifo_cnt"},   64'(fifo_cnt), 64'(q.size()));
    chk({where, "/res_thread"}, 64'(bus.res_thread), v ? 64'(q[0].thr)    : 64'd0);
    chk({where, "/res_exc"},    64'(bus.res_exc),    v ? 64'(q[0].exc)    : 64'd0);
    chk({where, "/res_fcmpop"}, 64'(bus.res_fcmpop), v ? 64'(q[0].fcmpop) : 64'd0);
    chk({where, "/res_cc"},     64'(bus.res_cc),     v ? 64'(q[0].cc)     : 64'd0);
    chk({where, "/res_fcc"},    64'(bus.res_fcc),    v ? 64'(q[0].fcc)    : 64'd0);
    chk({where, "/res_data"},   bus.res_data,        v ? q[0].data        : 64'd0);
    chk({where, "/err_fmt"},    64'(err_fmt),   64'(m_fmt));
    chk({where, "/err_ovf"},    64'(err_ovf),   64'(m_ovf));
    chk({where, "/err_unexp"},  64'(err_unexp), 64'(m_unexp));
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s/pend%0d", where, k), 64'(dut.pcnt_q[k]), 64'(pend[k]));
  endtask

  task automatic step(input string where);
    apply();
    model_edge();
    @(posedge rclk);
    #1;
    check_all(where);
  endtask

  initial begin
    int thr;
    int idx;

    // Reset state
    rst = 1'b1;
    pkt = '0; iv = 0; it = 0; rdy = 0; clr = 0;
    apply();
    model_reset();
    #1;
    check_all("reset");
    #10;
    rst = 1'b0;

    // Single issue/return on thread 2, one-cycle latency, then pop
    rdy = 1; iv = 1; it = 2; pkt = idle_pkt();
    step("issue_t2");
    iv = 0;
    pkt = mk(2, 5'h01, 1'b0, 2'b00, 2'b00, 64'h3FF0_0000_0000_0000, 4'b1000);
    step("ret_t2");
    pkt = idle_pkt();
    step("pop_t2");

    // Malformed: bad rtntype, then a reserved bit, clear racing an event
    iv = 1; it = 0; pkt = idle_pkt();
    step("issue_t0");
    iv = 0;
    pkt = mk(0, 5'h02, 1'b1, 2'b01, 2'b10, 64'h1234, 4'b0100);
    step("bad_rtntype");
    clr = 1; pkt = idle_pkt();
    step("clr_fmt");
    clr = 0;
    pkt = rnd_ret(0); pkt[100] = 1'b1;
    step("bad_rsvd");
    clr = 1; pkt = rnd_ret(0); pkt[64] = 1'b1;
    step("clr_vs_fmt");
    pkt = idle_pkt();
    step("clr_fmt2");
    clr = 0;

    // Unexpected return, then same-cycle issue+return on thread 1
    pkt = rnd_ret(1);
    step("unexp_t1");
    iv = 1; it = 1; pkt = rnd_ret(1);
    step("issue_ret_t1");
    iv = 0; pkt = idle_pkt();
    step("pop_t1");
    clr = 1;
    step("clr_unexp");
    clr = 0;

    // Overflow: fill to DEPTH with consumer stalled
    rdy = 0;
    for (int n = 0; n < 5; n++) begin
      iv = 1; it = 0; pkt = idle_pkt();
      step("ovf_issue");
    end
    iv = 0;
    for (int n = 0; n < 5; n++) begin
      pkt = rnd_ret(0);
      step("ovf_ret");
    end
    rdy = 1; pkt = rnd_ret(0);
    step("full_push_pop");
    pkt = idle_pkt();
    for (int n = 0; n < 4; n++) step("drain");
    clr = 1;
    step("clr_ovf");
    clr = 0;

    // Counter saturation, then issue+return at max
    for (int n = 0; n < PMAX + 2; n++) begin
      iv = 1; it = 3; pkt = idle_pkt();
      step("sat_issue");
    end
    iv = 1; it = 3; pkt = rnd_ret(3);
    step("sat_issue_ret");
    iv = 0; pkt = idle_pkt();
    step("sat_pop");

    // Reset mid-stream with queued entries and a set flag
    rdy = 0;
    pkt = rnd_ret(2);
    step("pre_rst_unexp");
    for (int n = 0; n < 3; n++) begin
      iv = 1; it = 1; pkt = rnd_ret(1);
      step("pre_rst_fill");
    end
    iv = 0; pkt = idle_pkt();
    apply();
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    #2;
    rst = 1'b0;
    rdy = 1; pkt = rnd_ret(3);
    step("post_rst_unexp");
    clr = 1; pkt = idle_pkt();
    step("post_rst_clr");
    clr = 0;

    // Random stream across pointer wrap
    for (int n = 0; n < 160; n++) begin
      iv  = ($urandom_range(0, 99) < 55);
      it  = $urandom_range(0, 3);
      rdy = $urandom_range(0, 1);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) < 65) begin
        thr = $urandom_range(0, 3);
        pkt = rnd_ret(thr);
        if ($urandom_range(0, 9) == 0) begin
          idx = $urandom_range(64, 143);
          pkt[idx] = ~pkt[idx];
        end
      end else begin
        pkt = idle_pkt();
      end
      step("rand");
    end
    iv = 0; rdy = 1; clr = 0; pkt = idle_pkt();
    for (int n = 0; n < DEPTH + 1; n++) step("final_drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fpu_cpx_rcv.md
FPU_CPX_RCV -- requirements
Module: fpu_cpx_rcv

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter PCNT_W, default 3, per-thread pending-counter width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: rclk in 1, global clock; rst in 1, active-high asynchronous reset.
REQ-004 SHALL have ports:
- fp_cpx_data_ca  in  145  FPU-to-CPX return packet
- issue_vld  in  1  FPU op issued this cycle
- issue_thread  in  2  thread of issued op
- res_vld  out  1  FIFO head valid
- res_rdy  in  1  consumer accepts head
- res_thread  out  2  head thread ID
- res_exc  out  5  head exception flags
- res_fcmpop  out  1  head compare-op flag
- res_cc  out  2  head condition code
- res_fcc  out  2  head passed-through fcc
- res_data  out  64  head result data
- fifo_cnt  out  log2(DEPTH)+1  occupancy
- err_fmt  out  1  sticky malformed-packet flag
- err_ovf  out  1  sticky FIFO-overflow flag
- err_unexp  out  1  sticky return-without-pending flag
- err_clr  in  1  clears all sticky flags

Function
REQ-005 SHALL treat fp_cpx_data_ca[144]=1 as a packet-valid cycle; all other bits are ignored when bit 144=0.
REQ-006 SHALL decode: [143:140] rtntype (must be 4'b1000), [139:135] reserved zero, [134:133] thread, [132:77] reserved zero, [76:72] exc, [71:70] reserved zero, [69] fcmpop, [68:67] cc, [66:65] fcc, [64] reserved zero, [63:0] data.
REQ-007 SHALL flag a valid packet as malformed if rtntype != 4'b1000 or any reserved bit is nonzero; malformed packets are dropped and set err_fmt.
REQ-008 SHALL keep one saturating PCNT_W-bit pending counter per thread: +1 on issue_vld for issue_thread, -1 on accepted well-formed return for that thread, unchanged when both occur in the same cycle for the same thread, held at max on increment, never decremented below 0.
REQ-009 SHALL drop a well-formed return whose thread counter is 0 (and no same-cycle issue for that thread) and set err_unexp.
REQ-010 SHALL push each well-formed, expected return into the FIFO as {thread, exc, fcmpop, cc, fcc, data}.
REQ-011 SHALL pop the head on res_vld & res_rdy; res_rdy while empty has no effect.
REQ-012 SHALL accept a push when full only if a pop occurs in the same cycle (occupancy unchanged); otherwise drop the packet, set err_ovf, and leave the pending counter unchanged.
REQ-013 SHALL present a packet sampled at edge N on res_* after edge N when FIFO was empty (1-cycle latency); res_* SHALL hold stable while res_vld=1 and res_rdy=0.
REQ-014 SHALL wrap read/write pointers modulo DEPTH; fifo_cnt ranges 0..DEPTH.
REQ-015 SHALL set sticky flags on the event edge; err_clr clears them, and a same-cycle new event wins over err_clr.
REQ-016 SHALL drive res_* data outputs to 0 when res_vld=0.

Reset
REQ-017 SHALL, on rst assertion, immediately and asynchronously clear pointers, fifo_cnt, all pending counters and all err_* flags; res_vld=0 and res_* outputs=0.
REQ-018 SHALL discard FIFO contents on reset mid-operation; the first packet after rst deassertion is evaluated against zeroed pending counters.

Structure
REQ-019 SHALL place packet bit-position constants, the RTNTYPE_FPU=4'b1000 constant and the FIFO entry record type in a shared package fpu_cpx_pkg.
REQ-020 SHALL implement the storage as one sub-module fpu_cpx_rcv_fifo (parameterised width/depth, count, full/empty); decode, pending counters and error flags stay in the top.

Verification
REQ-021 Issue thread 2, return {1,1000,...,thread=2,exc=5'h01,data=64'h3FF0_0000_0000_0000}, res_rdy=1 -> res_vld next cycle with those values, thread 2 pending 1->0.
REQ-022 Valid packet rtntype=4'b0100 -> dropped, err_fmt=1, fifo_cnt unchanged; err_clr -> err_fmt=0.
REQ-023 Return for thread 1 with no issue -> dropped, err_unexp=1; same-cycle issue+return thread 1 -> accepted, counter stays 0.
REQ-024 res_rdy=0, 5 expected returns with DEPTH=4 -> fifo_cnt=4, 5th dropped, err_ovf=1; 5th with res_rdy=1 in same cycle -> accepted, fifo_cnt=4.
REQ-025 Fill 3 entries, assert rst mid-stream -> res_vld=0, fifo_cnt=0, flags 0 without a clock edge; next return -> err_unexp=1.
REQ-026 Stream 10 returns, random res_rdy -> in-order delivery across pointer wrap, no loss, no duplication.
